// File: rtl/digit_stream_tx.sv
// digit_stream_tx: converts a binary value to NUM_DIGITS decimal digits and streams them MSD first over valid/ready.
// Define DIGIT_STREAM_CHECKSUM_EN to append a modulo-2**SYM_W checksum symbol to every frame.
module digit_stream_tx #(
    parameter int NUM_W      = 32,
    parameter int NUM_DIGITS = 6,
    parameter int SYM_W      = 4
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [SYM_W-1:0] sym,
    output logic             sym_valid,
    input  logic             sym_ready
);
    localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
`ifdef DIGIT_STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, CONV, SEND, SUM, FIN} state_t;
    localparam state_t AFTER_SEND = SUM;
`else
    typedef enum logic [2:0] {IDLE, CONV, SEND, FIN} state_t;
    localparam state_t AFTER_SEND = FIN;
`endif
    state_t                     state_q, state_d;
    logic [NUM_W-1:0]           work_q, work_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
    logic                       ovf_q, ovf_d;
    logic [3:0]                 rem;
    logic                       xfer;
`ifdef DIGIT_STREAM_CHECKSUM_EN
    logic [SYM_W-1:0]           sum_q, sum_d;
`endif
    // idx counts digits up during CONV and ends on NUM_DIGITS-1, exactly where SEND starts counting down
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        idx_d   = idx_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
`ifdef DIGIT_STREAM_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        rem     = 4'(work_q % NUM_W'(10));
        xfer    = sym_valid && sym_ready;
        case (state_q)
            IDLE: if (start) begin
                state_d = CONV;
                work_d  = num;
                idx_d   = '0;
                ovf_d   = 1'b0;
`ifdef DIGIT_STREAM_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            CONV: begin
                dig_d[idx_q] = rem;
                work_d       = work_q / NUM_W'(10);
                if (idx_q == CW'(NUM_DIGITS - 1)) begin
                    state_d = SEND;
                    ovf_d   = work_d != '0;
                end else idx_d = idx_q + 1'b1;
            end
            SEND: if (xfer) begin
`ifdef DIGIT_STREAM_CHECKSUM_EN
                sum_d = sum_q + sym;
`endif
                if (idx_q == '0) state_d = AFTER_SEND;
                else idx_d = idx_q - 1'b1;
            end
`ifdef DIGIT_STREAM_CHECKSUM_EN
            SUM: if (xfer) state_d = FIN;
`endif
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            idx_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef DIGIT_STREAM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
`ifdef DIGIT_STREAM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
    assign busy     = state_q != IDLE && state_q != FIN;
    assign done     = state_q == FIN;
    assign overflow = ovf_q;
`ifdef DIGIT_STREAM_CHECKSUM_EN
    assign sym_valid = state_q == SEND || state_q == SUM;
    assign sym       = state_q == SEND ? dig_q[idx_q][SYM_W-1:0] : state_q == SUM ? sum_q : '0;
`else
    assign sym_valid = state_q == SEND;
    assign sym       = state_q == SEND ? dig_q[idx_q][SYM_W-1:0] : '0;
`endif
endmodule
